// File: rtl/song_sequencer.sv
// rtl/song_sequencer.sv - walks the song ROM and hands notes to the note player
module song_sequencer #(
  parameter int ADDR_W = 5,
  parameter int NOTE_W = 6,
  parameter int DUR_W  = 6
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     play,
  input  logic                     reset_player,
  input  logic [1:0]               song,
  output logic [ADDR_W+1:0]        rom_addr,
  input  logic [NOTE_W+DUR_W-1:0]  rom_data,
  output logic [NOTE_W-1:0]        note_out,
  output logic [DUR_W-1:0]         duration_out,
  output logic                     new_note,
  input  logic                     note_done,
  output logic                     song_done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_CHECK,
    S_PLAYING,
    S_DONE
  } state_t;

  state_t              r_state;
  logic [ADDR_W-1:0]   r_idx;
  logic [NOTE_W-1:0]   r_note;
  logic [DUR_W-1:0]    r_dur;
  logic                r_new_note;
  logic                r_song_done;

  logic [NOTE_W-1:0]   w_rom_note;
  logic [DUR_W-1:0]    w_rom_dur;
  logic                w_end_marker;
  logic                w_last_idx;

  // ROM word is {note, duration}; a zero duration marks the end of the song
  assign w_rom_note   = rom_data[NOTE_W+DUR_W-1:DUR_W];
  assign w_rom_dur    = rom_data[DUR_W-1:0];
  assign w_end_marker = (w_rom_dur == '0);
  assign w_last_idx   = (r_idx == {ADDR_W{1'b1}});

  assign rom_addr     = {song, r_idx};
  assign note_out     = r_note;
  assign duration_out = r_dur;
  assign new_note     = r_new_note;
  assign song_done    = r_song_done;

  // Sequencer FSM: pulses are set on entry to PLAYING/DONE and cleared one edge later
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state     <= S_IDLE;
      r_idx       <= '0;
      r_note      <= '0;
      r_dur       <= '0;
      r_new_note  <= 1'b0;
      r_song_done <= 1'b0;
    end else if (reset_player) begin
      // Restart keeps the last note values so the player output is not disturbed
      r_state     <= S_IDLE;
      r_idx       <= '0;
      r_new_note  <= 1'b0;
      r_song_done <= 1'b0;
    end else begin
      r_new_note  <= 1'b0;
      r_song_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (play) r_state <= S_WAIT;
        end
        S_WAIT: begin
          // One cycle for the registered ROM to present data for the new address
          r_state <= S_CHECK;
        end
        S_CHECK: begin
          if (w_end_marker) begin
            r_state     <= S_DONE;
            r_song_done <= 1'b1;
          end else if (play) begin
            r_note     <= w_rom_note;
            r_dur      <= w_rom_dur;
            r_new_note <= 1'b1;
            r_state    <= S_PLAYING;
          end
        end
        S_PLAYING: begin
          if (note_done) begin
            if (w_last_idx) begin
              r_state     <= S_DONE;
              r_song_done <= 1'b1;
            end else begin
              r_idx   <= r_idx + ADDR_W'(1);
              r_state <= S_WAIT;
            end
          end
        end
        S_DONE: begin
          r_idx   <= '0;
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_song_sequencer.sv
// tb/tb_song_sequencer.sv - directed self-checking bench for song_sequencer
module tb_song_sequencer;

  logic        clk;
  logic        reset;
  logic        play;
  logic        reset_player;
  logic [1:0]  song;
  logic [6:0]  rom_addr;
  logic [11:0] rom_data;
  logic [5:0]  note_out;
  logic [5:0]  duration_out;
  logic        new_note;
  logic        note_done;
  logic        song_done;

  logic [11:0] rom [0:127];

  int checks = 0;
  int errors = 0;

  song_sequencer #(.ADDR_W(5), .NOTE_W(6), .DUR_W(6)) dut (
    .clk          (clk),
    .reset        (reset),
    .play         (play),
    .reset_player (reset_player),
    .song         (song),
    .rom_addr     (rom_addr),
    .rom_data     (rom_data),
    .note_out     (note_out),
    .duration_out (duration_out),
    .new_note     (new_note),
    .note_done    (note_done),
    .song_done    (song_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Registered song ROM: data valid one cycle after the address
  always @(posedge clk) rom_data <= rom[rom_addr];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Bounded wait for new_note; a timeout is recorded as a failed check
  task automatic wait_new_note(input string tag);
    int n;
    n = 0;
    while (new_note !== 1'b1 && n < 10) begin
      tick();
      n++;
    end
    chk(tag, {31'd0, new_note}, 32'd1);
  endtask

  initial begin
    for (int a = 0; a < 128; a++) rom[a] = 12'h041;
    rom[0] = {6'd12, 6'd8};
    rom[1] = {6'd20, 6'd4};
    rom[2] = {6'd5,  6'd0};
    for (int i = 0; i < 32; i++) rom[32 + i] = {6'(i + 3), 6'(i + 1)};

    reset = 1'b0; play = 1'b0; reset_player = 1'b0; note_done = 1'b0; song = 2'd2;
    tick();
    tick();
    chk("rst_note", {26'd0, note_out}, 32'd0);
    chk("rst_dur", {26'd0, duration_out}, 32'd0);
    chk("rst_new_note", {31'd0, new_note}, 32'd0);
    chk("rst_song_done", {31'd0, song_done}, 32'd0);
    chk("rst_addr", {25'd0, rom_addr}, 32'h40);

    // First note of song 0
    reset = 1'b1; song = 2'd0; play = 1'b1;
    tick();
    chk("start_e0_nn", {31'd0, new_note}, 32'd0);
    tick();
    chk("start_e1_nn", {31'd0, new_note}, 32'd0);
    tick();
    chk("start_e2_nn", {31'd0, new_note}, 32'd1);
    chk("first_note", {26'd0, note_out}, 32'd12);
    chk("first_dur", {26'd0, duration_out}, 32'd8);
    chk("first_addr", {25'd0, rom_addr}, 32'd0);
    tick();
    chk("first_nn_low", {31'd0, new_note}, 32'd0);
    chk("first_note_hold", {26'd0, note_out}, 32'd12);

    // Advance to idx 1
    note_done = 1'b1;
    tick();
    note_done = 1'b0;
    chk("adv_addr", {25'd0, rom_addr}, 32'd1);
    chk("adv_nn0", {31'd0, new_note}, 32'd0);
    tick();
    chk("adv_nn1", {31'd0, new_note}, 32'd0);
    tick();
    chk("adv_nn2", {31'd0, new_note}, 32'd1);
    chk("adv_note", {26'd0, note_out}, 32'd20);
    chk("adv_dur", {26'd0, duration_out}, 32'd4);
    tick();

    // End marker at idx 2
    note_done = 1'b1;
    tick();
    note_done = 1'b0;
    chk("end_addr", {25'd0, rom_addr}, 32'd2);
    tick();
    chk("end_nn_check", {31'd0, new_note}, 32'd0);
    chk("end_sd_check", {31'd0, song_done}, 32'd0);
    tick();
    chk("end_song_done", {31'd0, song_done}, 32'd1);
    chk("end_nn_done", {31'd0, new_note}, 32'd0);
    play = 1'b0;
    tick();
    chk("end_sd_low", {31'd0, song_done}, 32'd0);
    chk("end_nn_idle", {31'd0, new_note}, 32'd0);
    chk("end_addr_zero", {25'd0, rom_addr}, 32'd0);
    tick();
    chk("end_idle_nn", {31'd0, new_note}, 32'd0);

    // Full 32-note song 1
    reset_player = 1'b1; song = 2'd1;
    tick();
    reset_player = 1'b0;
    play = 1'b1;
    for (int i = 0; i < 32; i++) begin
      wait_new_note("full_nn_wait");
      chk("full_note", {26'd0, note_out}, 32'(i + 3));
      chk("full_dur", {26'd0, duration_out}, 32'(i + 1));
      chk("full_addr", {25'd0, rom_addr}, 32'(32 + i));
      tick();
      chk("full_nn_pulse", {31'd0, new_note}, 32'd0);
      chk("full_sd_early", {31'd0, song_done}, 32'd0);
      note_done = 1'b1;
      tick();
      note_done = 1'b0;
    end
    chk("full_song_done", {31'd0, song_done}, 32'd1);
    chk("full_sd_nn", {31'd0, new_note}, 32'd0);
    play = 1'b0;
    tick();
    chk("full_sd_low", {31'd0, song_done}, 32'd0);
    chk("full_addr_zero", {25'd0, rom_addr}, 32'd32);
    tick();
    tick();
    chk("full_idle_nn", {31'd0, new_note}, 32'd0);

    // Pause while in CHECK
    reset_player = 1'b1;
    tick();
    reset_player = 1'b0;
    play = 1'b1;
    wait_new_note("pause_first_wait");
    chk("pause_first_note", {26'd0, note_out}, 32'd3);
    tick();
    note_done = 1'b1; play = 1'b0;
    tick();
    note_done = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("pause_held", {31'd0, new_note}, 32'd0);
    end
    play = 1'b1;
    tick();
    chk("pause_resume_nn", {31'd0, new_note}, 32'd1);
    chk("pause_resume_note", {26'd0, note_out}, 32'd4);
    chk("pause_resume_dur", {26'd0, duration_out}, 32'd2);
    tick();

    // reset_player wins over note_done
    note_done = 1'b1; reset_player = 1'b1;
    tick();
    note_done = 1'b0; reset_player = 1'b0; play = 1'b0;
    chk("rp_nn", {31'd0, new_note}, 32'd0);
    chk("rp_sd", {31'd0, song_done}, 32'd0);
    chk("rp_addr", {25'd0, rom_addr}, 32'd32);
    chk("rp_note_kept", {26'd0, note_out}, 32'd4);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("rp_quiet_nn", {31'd0, new_note}, 32'd0);
      chk("rp_quiet_sd", {31'd0, song_done}, 32'd0);
    end

    // Reset clears the note outputs
    reset = 1'b0;
    tick();
    reset = 1'b1;
    chk("rst2_note", {26'd0, note_out}, 32'd0);
    chk("rst2_dur", {26'd0, duration_out}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/song_sequencer.md
# song_sequencer

Sequences note playback for the currently selected song. It walks the song ROM one note at a time, hands each note and its duration to the note player with a one-cycle `new_note` pulse, and waits for `note_done` before fetching the next note. At end of song it raises `song_done` toward the MCU. It sits between the MCU (`play`, `reset_player`, `song`) and the song ROM / note player datapath.

## Interface
- `ADDR_W`, default 5: note-index width; each song holds 2^ADDR_W notes.
- `NOTE_W`, default 6: note code width.
- `DUR_W`, default 6: duration width.
- `clk`, input, 1: system clock. Everything is rising-edge.
- `reset`, input, 1: one clock; reset is synchronous and active-low. `reset`=0 at an edge resets the block.
- `play`, input, 1: level from the MCU. 1 = playing, 0 = paused.
- `reset_player`, input, 1: level from the MCU. Synchronous restart of the current song.
- `song`, input, 2: selected song.
- `rom_addr`, output, ADDR_W+2: combinational `{song, idx}`.
- `rom_data`, input, NOTE_W+DUR_W: `{note, duration}`. The ROM is registered, so data is valid one cycle after the address is presented.
- `note_out`, output, NOTE_W: registered note handed to the note player.
- `duration_out`, output, DUR_W: registered duration handed to the note player.
- `new_note`, output, 1: one-cycle pulse. `note_out` and `duration_out` are valid while it is high.
- `note_done`, input, 1: pulse from the note player when the current note has finished.
- `song_done`, output, 1: one-cycle pulse at end of song.

## Operation
- Internal state: note index `idx` (ADDR_W bits) and FSM state in {IDLE, WAIT, CHECK, PLAYING, DONE}.
- Priority at every edge: `reset`=0, then `reset_player`=1, then FSM transitions.
- Effect of reset or `reset_player`:
  - state = IDLE, `idx` = 0;
  - `new_note` = 0 and `song_done` = 0;
  - `note_out` and `duration_out` are cleared to 0 by reset only; `reset_player` leaves them unchanged.
- FSM transitions:
  - IDLE: if `play`=1, go to WAIT; else stay in IDLE.
  - WAIT: always go to CHECK. This one cycle covers ROM latency.
  - CHECK, when `rom_data` duration field == 0 (end marker): go to DONE; `play` is ignored.
  - CHECK, when duration != 0 and `play`=1: latch `note_out`/`duration_out` from `rom_data`, set `new_note`=1 for the next cycle, go to PLAYING.
  - CHECK, when duration != 0 and `play`=0: stay in CHECK. The address is stable, so the data is held.
  - PLAYING, on `note_done`=1 with `idx` == 2^ADDR_W−1: go to DONE.
  - PLAYING, on `note_done`=1 otherwise: `idx` += 1, go to WAIT.
  - PLAYING, no `note_done`: stay, regardless of `play`. Pausing is handled by the note player.
  - DONE: `song_done`=1 for this one cycle, `idx` = 0, go to IDLE.
- `note_done` is honoured only in PLAYING; it is ignored in every other state.
- `new_note` is asserted only in the first cycle of PLAYING.
- `idx` wraps to 0 only through DONE. It never overflows silently.
- A change of `song` without `reset_player` is not guarded; `rom_addr` follows `song` immediately. The MCU always pairs a song change with `reset_player`.

## Timing
- Reset values: state IDLE, `idx`=0, `note_out`=0, `duration_out`=0, `new_note`=0, `song_done`=0, `rom_addr`={song, 0}.
- Start latency: `play` sampled high in IDLE at edge t → WAIT after t, CHECK after t+1, `new_note`=1 during the cycle after edge t+2.
- Note-to-note latency: `note_done` sampled at edge t → `rom_addr` increments after t, CHECK after t+1, `new_note` during the cycle after t+2.
- End latency: the end marker in CHECK at edge t → `song_done` high during the cycle after t, state IDLE after t+1.
- `song_done` and `new_note` are never high in the same cycle.
- `reset_player` or `reset` in any state takes effect at that edge:
  - a pending `new_note` or `song_done` is cancelled, so the output is low in the next cycle;
  - no `song_done` is produced.

## Test plan
- Reset: hold `reset`=0 for 2 cycles with `song`=2 → all outputs 0, `rom_addr`=7'b10_00000, state IDLE.
- First note: song 0, idx 0 = {12, 8}; raise `play` before edge 0 → `new_note`=1 for exactly one cycle after edge 2, with `note_out`=12 and `duration_out`=8; `rom_addr`=0 throughout.
- Advance: pulse `note_done` in PLAYING → `rom_addr`=1 the next cycle; idx 1 = {20, 4} appears with `new_note` after 3 edges.
- End marker: idx 2 duration = 0 → after `note_done` for idx 1, one `song_done` pulse, no `new_note`, `rom_addr` returns to {song, 0}.
- Full song: 32 non-zero notes, answer each `new_note` with `note_done` → 32 `new_note` pulses, then `song_done` after the 32nd `note_done`, then idle.
- Pause and restart:
  - drop `play` while in CHECK → `new_note` is withheld until `play` returns, with the same note values;
  - `reset_player` and `note_done` in the same cycle → IDLE, `idx`=0, no `song_done`, no `new_note`.
